// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF) and data (D) ports.
// Optional IF anti-starvation counter enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_wstrb,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  stall_read
);

  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;

  state_t state, state_nxt;
  logic   owner_d;   // 1 = data port owns the in-flight transaction
  logic   force_if;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  // Counter cannot pass the limit: at the limit a waiting IF wins the next arbitration.
  always_ff @(posedge clk) begin
    if (reset || if_gnt || !if_req) starve_cnt <= '0;
    else if (d_gnt)                 starve_cnt <= starve_cnt + 1'b1;
  end

  assign force_if = if_req && (starve_cnt == CW'(STARVE_LIMIT));
`else
  assign force_if = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_gnt || d_gnt) state_nxt = CMD;
      CMD:     if (mem_req && mem_ready) state_nxt = mem_we ? DONE : RESP;
      RESP:    if (mem_rvalid) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants only in IDLE; D beats IF unless the starvation limit forces an IF turn.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset && state == IDLE) begin
      d_gnt  = d_req && !force_if;
      if_gnt = if_req && !d_gnt;
    end
    stall_read = !reset && ((state != IDLE && owner_d) || (d_req && !d_gnt));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_d   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'h0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_gnt) begin
            owner_d   <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb <= d_we ? d_wstrb : 4'h0;
            mem_wdata <= d_we ? d_wdata : 32'h0;
          end else if (if_gnt) begin
            owner_d   <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
          end
        end
        CMD: if (mem_ready) mem_req <= 1'b0;
        RESP: begin
          if (mem_rvalid) begin
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        DONE: begin
          d_rvalid <= 1'b1;
          d_rdata  <= 32'h0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int LIM = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_wstrb;
  logic [31:0]   d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ready, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          stall_read;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_read(stall_read)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction and its expected lifecycle.
  bit          busy, own_d, mreq_exp, rd_wait, wr_wait, pulse_if, pulse_d;
  bit          c_we, if_took, d_took, late_rv, did_rst;
  logic [31:0] c_addr, c_wdata, p_data;
  logic [3:0]  c_wstrb;
  int          starve, lat, rst_cnt, ifg_p1, dg_p1;
  bit          e_d, e_if, force_if, p1;

  task automatic model_reset();
    busy = 0; own_d = 0; mreq_exp = 0; rd_wait = 0; wr_wait = 0;
    pulse_if = 0; pulse_d = 0; starve = 0; lat = 0;
  endtask

  initial begin
    reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wstrb = 0; d_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    model_reset();
    if_took = 0; d_took = 0; late_rv = 0; did_rst = 0;
    rst_cnt = 2; ifg_p1 = 0; dg_p1 = 0;

    for (int cyc = 0; cyc < 2400; cyc++) begin
      @(posedge clk); #1;
      p1 = (cyc >= 1500 && cyc < 1900);
      // Reset in the middle of a command phase to abort a transaction.
      if (!did_rst && cyc >= 900 && mreq_exp) begin rst_cnt = 2; did_rst = 1; end

      if (rst_cnt > 0) begin
        reset = 1; if_req = 0; d_req = 0; mem_ready = 0; mem_rvalid = 0;
      end else begin
        reset = 0;
        if (!if_req || if_took) begin
          if_req  = p1 ? 1'b1 : ($urandom_range(0, 2) != 0);
          if_addr = $urandom;
        end
        if (!d_req || d_took) begin
          d_req   = p1 ? 1'b1 : ($urandom_range(0, 2) == 0);
          d_we    = $urandom_range(0, 1);
          d_addr  = $urandom & 32'hFFFF_FFFC;
          d_wstrb = $urandom;
          d_wdata = $urandom;
        end
        mem_ready  = ($urandom_range(0, 3) != 0);
        mem_rdata  = $urandom;
        mem_rvalid = 0;
        if (rd_wait) begin
          lat--;
          if (lat == 0) mem_rvalid = 1;
        end else if (late_rv || $urandom_range(0, 7) == 0) begin
          mem_rvalid = 1;   // stray response that must be ignored
        end
        late_rv = 0;
      end

      @(negedge clk);
      if (rst_cnt > 0) begin
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_stall", stall_read, 0);
        if (rst_cnt == 1) begin
          check("rst_mem_req", mem_req, 0);
          check("rst_mem_we", mem_we, 0);
          check("rst_mem_addr", mem_addr, 0);
          check("rst_mem_wstrb", mem_wstrb, 0);
          check("rst_mem_wdata", mem_wdata, 0);
          check("rst_if_rvalid", if_rvalid, 0);
          check("rst_if_rdata", if_rdata, 0);
          check("rst_d_rvalid", d_rvalid, 0);
          check("rst_d_rdata", d_rdata, 0);
        end
        if_took = 0; d_took = 0;
        rst_cnt--;
        if (rst_cnt == 0) begin model_reset(); late_rv = 1; end
      end else begin
        check("if_rvalid", if_rvalid, pulse_if);
        check("d_rvalid", d_rvalid, pulse_d);
        if (pulse_if) check("if_rdata", if_rdata, p_data);
        if (pulse_d)  check("d_rdata", d_rdata, p_data);
        if (pulse_if || pulse_d) busy = 0;
        pulse_if = 0; pulse_d = 0;

        check("mem_req", mem_req, mreq_exp);
        if (mreq_exp) begin
          check("mem_we", mem_we, c_we);
          check("mem_addr", mem_addr, c_addr);
          check("mem_wstrb", mem_wstrb, c_wstrb);
          if (c_we) check("mem_wdata", mem_wdata, c_wdata);
        end

        force_if = FAIR && if_req && starve >= LIM;
        e_d  = !busy && d_req && !force_if;
        e_if = !busy && if_req && !e_d;
        check("d_gnt", d_gnt, e_d);
        check("if_gnt", if_gnt, e_if);
        check("stall_read", stall_read, (busy && own_d) || (d_req && !e_d));

        if (wr_wait) begin pulse_d = 1; p_data = 0; wr_wait = 0; end
        if (rd_wait && mem_rvalid) begin
          if (own_d) pulse_d = 1; else pulse_if = 1;
          p_data = mem_rdata; rd_wait = 0;
        end
        if (mreq_exp && mem_ready) begin
          mreq_exp = 0;
          if (c_we) wr_wait = 1;
          else begin rd_wait = 1; lat = $urandom_range(1, 5); end
        end
        if (e_d) begin
          busy = 1; own_d = 1; mreq_exp = 1; c_we = d_we;
          c_addr = d_addr & 32'hFFFF_FFFC; c_wstrb = d_we ? d_wstrb : 4'h0; c_wdata = d_wdata;
        end else if (e_if) begin
          busy = 1; own_d = 0; mreq_exp = 1; c_we = 0;
          c_addr = if_addr & 32'hFFFF_FFFC; c_wstrb = 4'h0; c_wdata = 0;
        end
        if (!if_req || e_if) starve = 0;
        else if (e_d)        starve++;
        if (p1 && e_if) ifg_p1++;
        if (p1 && e_d)  dg_p1++;
        if_took = e_if; d_took = e_d;
      end
    end

    check("p1_d_grants_seen", dg_p1 != 0, 1);
    check("p1_if_granted", ifg_p1 != 0, FAIR);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
